// File: rtl/async2sync_bridge.sv
// -----------------------------------------------------------------------------
// async2sync_bridge
//
// Consumer stage that sits directly behind a join/Muller reduction. It accepts
// the merged 4-phase bundled-data request (req_in + data_in), returns the
// acknowledge, and re-times each item into a clocked valid/ready stream.
// It also counts fully completed 4-phase cycles and raises a sticky flag when
// upstream withdraws a request before it has been acknowledged.
//
// Configuration macro:
//   A2S_SYNC3_EN  - when defined, req_in goes through a 3-flop synchronizer
//                   instead of 2. Each request edge then takes one clock
//                   longer to reach the FSM. Nothing else changes.
//
// Parameters:
//   width      - bundled data width
//   cnt_width  - width of the completed-transfer counter (wraps silently)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   req_in     in   4-phase request from upstream
//   ack_in     out  4-phase acknowledge to upstream (straight from a flop)
//   data_in    in   bundled data, stable while req_in=1
//   dout       out  captured data for the synchronous consumer
//   valid      out  dout valid
//   ready      in   consumer accepts dout when valid&ready at a clk edge
//   xfer_cnt   out  number of completed 4-phase cycles, modulo 2^cnt_width
//   proto_err  out  sticky protocol-violation flag, cleared only by rst
// -----------------------------------------------------------------------------
module async2sync_bridge #(
   parameter int width     = 8,
   parameter int cnt_width = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_in,
   output logic                 ack_in,
   input  logic [width-1:0]     data_in,
   output logic [width-1:0]     dout,
   output logic                 valid,
   input  logic                 ready,
   output logic [cnt_width-1:0] xfer_cnt,
   output logic                 proto_err
);

`ifdef A2S_SYNC3_EN
   localparam int sync_len = 3;
`else
   localparam int sync_len = 2;
`endif

   localparam logic [cnt_width-1:0] cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      VALID = 2'b01,
      ACK   = 2'b10
   } state_t;

   logic [sync_len-1:0]  sync_r;
   logic                 req_s;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [width-1:0]     dout_r;
   logic [width-1:0]     dout_nxt_s;
   logic                 valid_r;
   logic                 valid_nxt_s;
   logic                 ack_r;
   logic                 ack_nxt_s;
   logic [cnt_width-1:0] cnt_r;
   logic [cnt_width-1:0] cnt_nxt_s;
   logic                 err_r;
   logic                 err_nxt_s;

   // req_in synchronizer shift chain; the last stage is the only copy the FSM sees
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_r <= {sync_len{1'b0}};
      end else begin
         sync_r <= {sync_r[sync_len-2:0], req_in};
      end
   end

   assign req_s = sync_r[sync_len-1];

   // State and output registers; every output comes straight from a flop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         dout_r  <= {width{1'b0}};
         valid_r <= 1'b0;
         ack_r   <= 1'b0;
         cnt_r   <= {cnt_width{1'b0}};
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         dout_r  <= dout_nxt_s;
         valid_r <= valid_nxt_s;
         ack_r   <= ack_nxt_s;
         cnt_r   <= cnt_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   // Next-state and next-output logic of the 4-phase to valid/ready FSM
   always_comb begin
      state_nxt_s = state_r;
      dout_nxt_s  = dout_r;
      valid_nxt_s = valid_r;
      ack_nxt_s   = ack_r;
      cnt_nxt_s   = cnt_r;
      err_nxt_s   = err_r;

      case (state_r)
         IDLE: begin
            // By the time req_s is seen, data_in has been stable for at
            // least the synchronizer depth, so sampling it here is safe.
            if (req_s) begin
               dout_nxt_s  = data_in;
               valid_nxt_s = 1'b1;
               state_nxt_s = VALID;
            end else begin
               valid_nxt_s = 1'b0;
               ack_nxt_s   = 1'b0;
            end
         end
         VALID: begin
            // A withdrawn request takes priority over a simultaneous ready:
            // the item is dropped unacknowledged and the count is untouched.
            if (!req_s) begin
               err_nxt_s   = 1'b1;
               valid_nxt_s = 1'b0;
               state_nxt_s = IDLE;
            end else if (ready) begin
               valid_nxt_s = 1'b0;
               ack_nxt_s   = 1'b1;
               state_nxt_s = ACK;
            end else begin
               valid_nxt_s = 1'b1;
            end
         end
         ACK: begin
            // Return-to-zero phase; the transfer only counts once it is over.
            if (!req_s) begin
               ack_nxt_s   = 1'b0;
               cnt_nxt_s   = cnt_r + cnt_one;
               state_nxt_s = IDLE;
            end else begin
               ack_nxt_s   = 1'b1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
            ack_nxt_s   = 1'b0;
         end
      endcase
   end

   assign ack_in    = ack_r;
   assign dout      = dout_r;
   assign valid     = valid_r;
   assign xfer_cnt  = cnt_r;
   assign proto_err = err_r;

endmodule

// File: tb/tb_async2sync_bridge.sv
// -----------------------------------------------------------------------------
// Self-checking bench for async2sync_bridge.
// An upstream driver performs 4-phase handshakes (clean and withdrawn) and
// pushes the data it offers into an expected queue. A monitor pops and
// compares each item whenever the consumer side accepts it (valid&ready).
// A reference count of completed handshakes and a sticky error flag are kept
// as plain integers and compared against the DUT after each handshake.
// -----------------------------------------------------------------------------
module tb_async2sync_bridge;

   localparam int W  = 8;
   localparam int CW = 4;
`ifdef A2S_SYNC3_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic          clk      = 1'b0;
   logic          rst      = 1'b0;
   logic          req_in   = 1'b0;
   logic          ack_in;
   logic [W-1:0]  data_in  = 8'h00;
   logic [W-1:0]  dout;
   logic          valid;
   logic          ready    = 1'b1;
   logic [CW-1:0] xfer_cnt;
   logic          proto_err;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  sb_e;
   int            model_cnt = 0;
   logic          exp_err   = 1'b0;
   int            ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

   async2sync_bridge #(.width(W), .cnt_width(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .ack_in    (ack_in),
      .data_in   (data_in),
      .dout      (dout),
      .valid     (valid),
      .ready     (ready),
      .xfer_cnt  (xfer_cnt),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // consumer ready generator
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       ready = 1'b0;
         1:       ready = 1'b1;
         default: ready = 1'($urandom_range(0, 1));
      endcase
   end

   // scoreboard monitor: an item is consumed at the edge after valid&ready is seen
   always @(negedge clk) begin
      if (rst && valid && ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got %0h expected none", dout);
         end else begin
            sb_e = exp_q.pop_front();
            check("sb_dout", 32'(dout), 32'(sb_e));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic get_sig(input int sel);
      case (sel)
         0:       return valid;
         1:       return ack_in;
         default: return proto_err;
      endcase
   endfunction

   task automatic wait_for(input int sel, input logic val, input int max, input string nm);
      int n = 0;
      while (get_sig(sel) !== val && n < max) begin
         tick();
         n++;
      end
      check(nm, 32'(get_sig(sel)), 32'(val));
   endtask

   task automatic do_xfer(input logic [W-1:0] d);
      data_in = d;
      req_in  = 1'b1;
      exp_q.push_back(d);
      wait_for(1, 1'b1, 300, "ack_rise");
      req_in  = 1'b0;
      wait_for(1, 1'b0, 20, "ack_fall");
      model_cnt = (model_cnt + 1) % (1 << CW);
      check("xfer_cnt", 32'(xfer_cnt), 32'(model_cnt));
      check("proto_err_hold", 32'(proto_err), 32'(exp_err));
      data_in = W'($urandom);
   endtask

   task automatic do_err(input logic [W-1:0] d);
      int saved = ready_mode;
      ready_mode = 0;
      tick();
      tick();
      data_in = d;
      req_in  = 1'b1;
      wait_for(0, 1'b1, 20, "err_valid_rise");
      check("err_dout", 32'(dout), 32'(d));
      req_in  = 1'b0;
      wait_for(0, 1'b0, 20, "err_valid_fall");
      exp_err = 1'b1;
      check("err_ack_low", 32'(ack_in), 32'd0);
      check("err_flag", 32'(proto_err), 32'(exp_err));
      check("err_cnt_same", 32'(xfer_cnt), 32'(model_cnt));
      ready_mode = saved;
      tick();
   endtask

   // exact-latency single transfer with ready already high
   task automatic single_lat(input logic [W-1:0] d);
      data_in = d;
      req_in  = 1'b1;
      exp_q.push_back(d);
      for (int i = 1; i <= LAT; i++) begin
         tick();
         check("lat_valid", 32'(valid), 32'(i == LAT));
      end
      check("lat_dout", 32'(dout), 32'(d));
      tick();
      check("lat_valid_drop", 32'(valid), 32'd0);
      check("lat_ack_rise", 32'(ack_in), 32'd1);
      req_in = 1'b0;
      for (int i = 1; i <= LAT; i++) begin
         tick();
         check("lat_ack_fall", 32'(ack_in), 32'(i < LAT));
      end
      model_cnt = (model_cnt + 1) % (1 << CW);
      check("lat_cnt", 32'(xfer_cnt), 32'(model_cnt));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset held with request and ready asserted
      rst     = 1'b0;
      req_in  = 1'b1;
      data_in = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_ack", 32'(ack_in), 32'd0);
         check("rst_valid", 32'(valid), 32'd0);
         check("rst_dout", 32'(dout), 32'd0);
         check("rst_cnt", 32'(xfer_cnt), 32'd0);
         check("rst_err", 32'(proto_err), 32'd0);
      end
      req_in = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();

      // single transfer with exact latencies
      single_lat(8'hA5);

      // backpressure for 10 cycles
      ready_mode = 0;
      tick();
      tick();
      data_in = 8'h3C;
      req_in  = 1'b1;
      exp_q.push_back(8'h3C);
      wait_for(0, 1'b1, 20, "bp_valid_rise");
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid", 32'(valid), 32'd1);
         check("bp_dout", 32'(dout), 32'h3C);
         check("bp_ack", 32'(ack_in), 32'd0);
      end
      ready_mode = 1;
      tick();
      check("bp_ack_pre", 32'(ack_in), 32'd0);
      tick();
      check("bp_ack_rise", 32'(ack_in), 32'd1);
      check("bp_valid_drop", 32'(valid), 32'd0);
      req_in = 1'b0;
      wait_for(1, 1'b0, 20, "bp_ack_fall");
      model_cnt = (model_cnt + 1) % (1 << CW);
      check("bp_cnt", 32'(xfer_cnt), 32'(model_cnt));

      // counter wrap: 16 back-to-back transfers pass through all-ones -> 0
      for (int i = 0; i < 16; i++) begin
         do_xfer(W'($urandom));
      end
      check("wrap_no_err", 32'(proto_err), 32'd0);

      // protocol error, then a clean transfer still completes
      do_err(8'h5A);
      do_xfer(8'hC3);

      // randomized traffic with random backpressure and occasional withdrawals
      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            do_err(W'($urandom));
         end else begin
            do_xfer(W'($urandom));
         end
      end

      // reset in the middle of the ACK phase
      ready_mode = 1;
      tick();
      tick();
      data_in = 8'h96;
      req_in  = 1'b1;
      exp_q.push_back(8'h96);
      wait_for(1, 1'b1, 20, "mid_ack_rise");
      #1;
      rst = 1'b0;
      #1;
      check("mid_ack", 32'(ack_in), 32'd0);
      check("mid_valid", 32'(valid), 32'd0);
      check("mid_cnt", 32'(xfer_cnt), 32'd0);
      check("mid_err", 32'(proto_err), 32'd0);
      req_in    = 1'b0;
      model_cnt = 0;
      exp_err   = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      tick();
      check("post_rst_valid", 32'(valid), 32'd0);
      single_lat(8'hA5);
      check("post_rst_err", 32'(proto_err), 32'd0);

      tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
